// File: rtl/bird_motion.sv
// Vertical motion and life-cycle FSM for the flapping bird: rises on flaps,
// falls on idle frame ticks, dies on the floor or on a pipe hit.
module bird_motion #(
    parameter int START_ROW  = 8,
    parameter int MAX_ROW    = 15,
    parameter int RISE       = 2,
    parameter int FALL_TICKS = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic       flap,
    input  logic       tick,
    input  logic       hit,
    output logic [3:0] pos,
    output logic       alive,
    output logic       game_over
);

    localparam int CW = $clog2(FALL_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FLY  = 2'b01,
        DEAD = 2'b10
    } state_t;

    state_t        state, state_next;
    logic [3:0]    pos_next;
    logic [CW-1:0] fall_cnt, fall_cnt_next, fall_cnt_inc;
    logic          flap_latch, flap_latch_next;
    logic [4:0]    rise_sum;

    // Sum is one bit wider than pos so the clamp sees the true value.
    assign rise_sum     = {1'b0, pos} + 5'(RISE);
    assign fall_cnt_inc = fall_cnt + 1'b1;

    // NOTE: every signal is given a default first so no path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next      = state;
        pos_next        = pos;
        fall_cnt_next   = fall_cnt;
        flap_latch_next = flap_latch;
        unique case (state)
            IDLE: begin
                pos_next        = 4'(START_ROW);
                fall_cnt_next   = '0;
                flap_latch_next = 1'b0;
                if (start) state_next = FLY;
            end
            FLY: begin
                if (hit) begin
                    state_next      = DEAD;
                    flap_latch_next = 1'b0;
                end else if (tick) begin
                    if (flap_latch || flap) begin
                        pos_next        = (rise_sum > 5'(MAX_ROW)) ? 4'(MAX_ROW) : rise_sum[3:0];
                        flap_latch_next = 1'b0;
                        fall_cnt_next   = '0;
                    end else if (fall_cnt_inc == CW'(FALL_TICKS)) begin
                        fall_cnt_next = '0;
                        if (pos != 4'd0) pos_next   = pos - 4'd1;
                        else             state_next = DEAD;
                    end else begin
                        fall_cnt_next = fall_cnt_inc;
                    end
                end else if (flap) begin
                    flap_latch_next = 1'b1;
                end
            end
            DEAD: begin
                fall_cnt_next   = '0;
                flap_latch_next = 1'b0;
                if (start) begin
                    state_next = IDLE;
                    pos_next   = 4'(START_ROW);
                end
            end
            default: begin
                state_next      = IDLE;
                pos_next        = 4'(START_ROW);
                fall_cnt_next   = '0;
                flap_latch_next = 1'b0;
            end
        endcase
    end

    // NOTE: reset is synchronous here, so it sits inside the clocked branch rather than in the sensitivity list.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            pos        <= 4'(START_ROW);
            fall_cnt   <= '0;
            flap_latch <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state      <= state_next;
            pos        <= pos_next;
            fall_cnt   <= fall_cnt_next;
            flap_latch <= flap_latch_next;
        end
    end

    assign alive     = (state == FLY);
    assign game_over = (state == DEAD);

endmodule

// File: doc/bird_motion.md
BIRD_MOTION -- requirements
Module: bird_motion

Interface
REQ-001 Parameter: START_ROW, default 8, row loaded into pos on entry to IDLE.
REQ-002 Parameter: MAX_ROW, default 15, top row; pos never exceeds it.
REQ-003 Parameter: RISE, default 2, rows gained per consumed flap.
REQ-004 Parameter: FALL_TICKS, default 2, ticks without a flap per 1-row fall.
REQ-005 Port: Clock  input  1  the block's single clock, all state on its rising edge.
REQ-006 Port: Reset  input  1  synchronous active-high reset, sampled on rising Clock.
REQ-007 Port: start  input  1  level; begins a flight from IDLE, or returns DEAD to IDLE.
REQ-008 Port: flap  input  1  flap request, one-cycle pulse or held level, driven by the key-press pulse generator's set output.
REQ-009 Port: tick  input  1  one-cycle frame-enable pulse; motion updates only on tick.
REQ-010 Port: hit  input  1  pipe-collision flag from the playfield.
REQ-011 Port: pos  output  4  current bird row, 0 = floor row, registered.
REQ-012 Port: alive  output  1  high only in FLY, registered.
REQ-013 Port: game_over  output  1  high only in DEAD, registered.

Function
REQ-014 FSM states: IDLE, FLY, DEAD; all outputs decoded from registered state/pos only.
REQ-015 IDLE: pos = START_ROW, alive 0, game_over 0, fall counter 0, flap latch 0; start=1 -> FLY next cycle.
REQ-016 FLY: flap=1 on any cycle sets flap latch; latch held until consumed by a tick.
REQ-017 FLY tick with latch set or flap=1 that cycle: pos <= min(pos+RISE, MAX_ROW); latch cleared; fall counter cleared.
REQ-018 FLY tick with no flap: fall counter +1; when counter reaches FALL_TICKS: counter cleared, pos-1 if pos>0.
REQ-019 FLY tick, fall due, pos==0: -> DEAD, pos stays 0.
REQ-020 FLY hit=1: -> DEAD next cycle, pos frozen; hit has priority over tick/flap that cycle.
REQ-021 Held flap level: one rise per tick while held (level re-sets latch each cycle).
REQ-022 Flap outside FLY ignored; latch not set in IDLE or DEAD.
REQ-023 DEAD: pos, alive 0, game_over 1 held; start=1 -> IDLE next cycle (pos reloads START_ROW).
REQ-024 Latency: pos/state change visible one cycle after the qualifying tick/hit/start edge.
REQ-025 Saturation: pos arithmetic done at 5 bits, clamped to MAX_ROW; no wrap at either bound.
REQ-026 Fall counter width ceil(log2(FALL_TICKS+1)); never exceeds FALL_TICKS.
REQ-027 Unused state encodings recover to IDLE next cycle.

Reset
REQ-028 Reset=1 at rising Clock: state IDLE, pos START_ROW, alive 0, game_over 0, latch 0, counter 0; overrides all inputs.
REQ-029 Reset mid-flight or in DEAD behaves identically to REQ-028; no pending flap survives.

Verification
REQ-030 Reset, start, 4 ticks no flap -> pos 8,8,7,7,6 (after each tick); alive 1.
REQ-031 In FLY pos 8, flap pulse 3 cycles before tick -> pos 10 after tick; next tick no flap -> pos 10.
REQ-032 pos 14, flap at tick -> 15; flap held 3 ticks -> pos stays 15, no death.
REQ-033 pos 0, 2 ticks no flap -> game_over 1, alive 0, pos 0; flap ignored; start -> IDLE, pos 8.
REQ-034 hit and tick+flap same cycle at pos 9 -> DEAD, pos 9.
REQ-035 Reset asserted during FLY with latch set -> IDLE, pos 8; after start, first tick without flap leaves pos 8.
